key_debouncer: RTL and testbench
================================

// Module: key_debouncer
//
// PURPOSE
//  Conditions raw active-low DE2 pushbuttons (KEY[n]) for the lab FSMs.
//  Per key: synchronise to clk, debounce, then emit a clean pressed level
//  and one-cycle press/release pulses. Sits directly upstream of the FSM
//  step input, so one physical press advances the FSM exactly one state.
//
// PARAMETERS
//  N_KEYS           4        number of independent key lanes
//  SYNC_STAGES      2        synchroniser flops per lane, >=2
//  DEBOUNCE_CYCLES  500000   stable cycles required (10 ms @ 50 MHz), >=1
//
// PORTS
//  clk            in   1        system clock (CLOCK_50)
//  reset          in   1        asynchronous, active-high
//  key_n          in   N_KEYS   raw buttons, 0 = pressed, asynchronous
//  pressed        out  N_KEYS   debounced level, 1 = held
//  press_pulse    out  N_KEYS   1-cycle strobe on debounced press
//  release_pulse  out  N_KEYS   1-cycle strobe on debounced release
//
// BEHAVIOUR
//  - One clock, clk; reset is asynchronous and active-high. All flops reset
//    asynchronously. Sync flops reset to 1 (released). State resets to UP.
//    Counters reset to 0. pressed, press_pulse and release_pulse reset to 0.
//  - Lanes are fully independent. No cross-lane interaction.
//  - Sync chain: s = key_n after SYNC_STAGES flops; FSM consumes ~s only.
//  - Per-lane FSM:
//      UP      : cnt=0; ~s -> ARMDN
//      ARMDN   : ~s -> cnt++; s -> UP (cnt=0, bounce rejected);
//                cnt==DEBOUNCE_CYCLES-1 && ~s -> DOWN, press_pulse=1
//      DOWN    : pressed=1; s -> ARMUP
//      ARMUP   : s -> cnt++; ~s -> DOWN (cnt=0);
//                cnt==DEBOUNCE_CYCLES-1 && s -> UP, release_pulse=1
//  - Outputs are registered. pressed = 1 in DOWN and ARMUP.
//    Pulses are high for exactly one cycle, on the cycle the FSM enters
//    DOWN or UP.
//  - Latency: key_n is sampled low at edge E0 and held. press_pulse is high
//    in the cycle after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES. pressed rises
//    in that same cycle. Release is symmetric.
//  - cnt width $clog2(DEBOUNCE_CYCLES+1). cnt never wraps; it clears on
//    every state change.
//  - Bounce: any glitch shorter than DEBOUNCE_CYCLES in ARMDN or ARMUP
//    restarts the window. No pulse is produced.
//  - DEBOUNCE_CYCLES=1: one stable sample after sync suffices.
//  - Reset mid-press: the lane restarts in UP. A key still held after
//    reset deasserts yields one press_pulse after the full latency.
//  - Simultaneous key activity across lanes is processed in parallel.
//
// STRUCTURE
//  - debounce_pkg: typedef enum logic [1:0] {UP, ARMDN, DOWN, ARMUP}
//    deb_state_t; function cnt_width(int cycles).
//  - Sub-module key_debounce_lane (sync chain + FSM + counter, 1 key).
//  - key_debouncer instantiates N_KEYS lanes via a generate loop.
//
// TESTING  (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, N_KEYS=2)
//  1 Reset asserted mid-run -> all outputs 0 immediately (async); sync=1.
//  2 key_n[0]=0 held from E0 -> press_pulse[0] high only in the cycle after
//    E6. pressed[0]=1 from then on. Lane 1 stays silent.
//  3 key_n[0] toggles 0/1 every 2 cycles for 20 cycles, then stays 1
//    -> no press_pulse, pressed stays 0.
//  4 Press held 10 cycles, then released -> release_pulse[0] high in the
//    cycle after release-E6. Exactly one press and one release pulse.
//  5 Hold key 0, assert reset for 3 cycles, release reset -> one
//    press_pulse 6 cycles after reset deasserts.
//  6 Both keys pressed at the same edge -> press_pulse=2'b11 in the same
//    cycle. A bounce on lane 1 alone delays lane 1 only.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared types and helpers for the pushbutton debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {UP, ARMDN, DOWN, ARMUP} deb_state_t;

  // Counter must hold values up to DEBOUNCE_CYCLES without wrapping.
  function automatic int cnt_width(int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/key_debounce_lane.sv
// One key: synchroniser chain, debounce FSM with stability counter,
// registered level and press/release strobes.
module key_debounce_lane
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   act;
  deb_state_t             state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   pressed_nxt, press_nxt, release_nxt;

  // Sync flops reset to released so a held key is seen only after the chain fills.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '1;
    else       sync <= {sync[SYNC_STAGES-2:0], key_n};
  end

  assign act = ~sync[SYNC_STAGES-1];

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      UP: begin
        cnt_nxt = '0;
        if (act) state_nxt = ARMDN;
      end
      ARMDN: begin
        if (!act) begin
          state_nxt = UP;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DOWN;
          cnt_nxt   = '0;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DOWN: begin
        cnt_nxt = '0;
        if (!act) state_nxt = ARMUP;
      end
      ARMUP: begin
        if (act) begin
          state_nxt = DOWN;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = UP;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = UP;
        cnt_nxt   = '0;
      end
    endcase
    pressed_nxt = (state_nxt == DOWN) || (state_nxt == ARMUP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= UP;
      cnt           <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      pressed       <= pressed_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

endmodule

// File: rtl/key_debouncer.sv
// Debounces N_KEYS independent active-low pushbuttons; each lane yields a
// clean pressed level plus one-cycle press and release strobes.
module key_debouncer
  import debounce_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_lane
    key_debounce_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk          (clk),
      .reset        (reset),
      .key_n        (key_n[i]),
      .pressed      (pressed[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i])
    );
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed checks of key_debouncer with 2 sync stages, 4-cycle window, 2 keys.
module tb_key_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] key_n;
  logic [1:0] pressed, press_pulse, release_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  key_debouncer #(
    .N_KEYS         (2),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clean_reset();
    key_n = 2'b11;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  int np, nr;

  initial begin
    reset = 1'b1;
    key_n = 2'b11;
    #2;
    chk("rst_pressed", 32'(pressed), 0);
    chk("rst_press_pulse", 32'(press_pulse), 0);
    chk("rst_release_pulse", 32'(release_pulse), 0);
    step();
    step();
    reset = 1'b0;
    step();

    // Key 0 held: strobe after E6, level stays up, lane 1 silent.
    key_n[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_press_pulse", 32'(press_pulse), (k == 6) ? 1 : 0);
      chk("hold_pressed", 32'(pressed), (k >= 6) ? 1 : 0);
      chk("hold_release_pulse", 32'(release_pulse), 0);
    end

    // Asynchronous reset mid-cycle clears the level immediately.
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_pressed", 32'(pressed), 0);
    chk("async_rst_press_pulse", 32'(press_pulse), 0);
    key_n = 2'b11;
    step();
    reset = 1'b0;
    step();

    // Bouncing key 0: toggles every 2 cycles, never stable for 4.
    for (int k = 0; k < 26; k++) begin
      key_n[0] = (k < 20) ? (((k / 2) % 2) != 0) : 1'b1;
      step();
      chk("bounce_press_pulse", 32'(press_pulse), 0);
      chk("bounce_pressed", 32'(pressed), 0);
    end

    // Press held 10 edges, then released at E10: release strobe after E16.
    clean_reset();
    key_n[0] = 1'b0;
    np = 0;
    nr = 0;
    for (int k = 0; k < 22; k++) begin
      if (k == 10) key_n[0] = 1'b1;
      step();
      np += int'(press_pulse[0]);
      nr += int'(release_pulse[0]);
      chk("pr_press_pulse", 32'(press_pulse), (k == 6) ? 1 : 0);
      chk("pr_release_pulse", 32'(release_pulse), (k == 16) ? 1 : 0);
      chk("pr_pressed", 32'(pressed), (k >= 6 && k < 16) ? 1 : 0);
    end
    chk("pr_press_count", 32'(np), 1);
    chk("pr_release_count", 32'(nr), 1);

    // Reset while key 0 held: one press strobe 6 edges after deassertion.
    clean_reset();
    key_n[0] = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk("pre_rst_pressed", 32'(pressed), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_press_rst_pressed", 32'(pressed), 0);
    step();
    step();
    step();
    reset = 1'b0;
    np = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      np += int'(press_pulse[0]);
      chk("rst_hold_press_pulse", 32'(press_pulse), (k == 6) ? 1 : 0);
      chk("rst_hold_pressed", 32'(pressed), (k >= 6) ? 1 : 0);
    end
    chk("rst_hold_press_count", 32'(np), 1);

    // Both keys at once; second run bounces lane 1 at E2 and delays it to E9.
    clean_reset();
    key_n = 2'b00;
    for (int k = 0; k < 9; k++) begin
      step();
      chk("both_press_pulse", 32'(press_pulse), (k == 6) ? 3 : 0);
    end
    clean_reset();
    key_n = 2'b00;
    for (int k = 0; k < 12; k++) begin
      if (k == 2) key_n[1] = 1'b1;
      if (k == 3) key_n[1] = 1'b0;
      step();
      chk("lane1_bounce_press_pulse", 32'(press_pulse),
          (k == 6) ? 1 : (k == 9) ? 2 : 0);
      chk("lane1_bounce_pressed", 32'(pressed),
          (k >= 9) ? 3 : (k >= 6) ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
